saradc_sar_ctrl: RTL

Digital successive-approximation controller for SARADC_ANALOG.
- Drives SAMPLE, RESULTP/RESULTN and VALID into the analog macro and reads CMPO back.
- Runs one conversion per START, or back-to-back conversions in continuous mode.
- Presents each finished code on a valid/ready output register with a sticky overrun flag.
- Clocked by the CLKBUF returned from the analog macro, in the same domain as the comparator.

---
 rtl/saradc_sar_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/saradc_sar_ctrl.sv
// rtl/saradc_sar_ctrl.sv - SAR conversion controller for SARADC_ANALOG; option macro SARADC_CTRL_CMP_SYNC_EN
module saradc_sar_ctrl #(
  parameter int NBITS = 8,
  parameter int NSAMP = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONT,
  input  logic             CMPO,
  output logic             SAMPLE,
  output logic [NBITS-1:0] RESULTP,
  output logic [NBITS-1:0] RESULTN,
  output logic             VALID,
  output logic             BUSY,
  output logic [NBITS-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             OVERRUN
);

  localparam int CW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [NBITS-1:0] MSB_TRIAL = NBITS'(1) << (NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    samp_cnt;
  logic [KW-1:0]    bit_idx;
  logic             cmp_bit;
  logic             decide_now;
  logic [NBITS-1:0] code_dec;
  logic [NBITS-1:0] mask_dec;
  logic [NBITS-1:0] resn_dec;

`ifdef SARADC_CTRL_CMP_SYNC_EN
  logic       cmp_meta;
  logic [1:0] phase;

  // cmp_meta is the first synchronizer stage; the RESULTP/DOUT decision flop is the second.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmp_meta <= 1'b0;
    end else begin
      cmp_meta <= CMPO;
    end
  end

  assign cmp_bit    = cmp_meta;
  assign decide_now = (phase == 2'd2);
`else
  assign cmp_bit    = CMPO;
  assign decide_now = 1'b1;
`endif

  // Code after deciding bit_idx, with the next lower bit raised as the new trial.
  always_comb begin
    code_dec = RESULTP;
    mask_dec = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (i == int'(bit_idx)) begin
        code_dec[i] = cmp_bit;
      end else if (i == int'(bit_idx) - 1) begin
        code_dec[i] = 1'b1;
      end
      mask_dec[i] = (i >= int'(bit_idx) - 1);
    end
    resn_dec = ~code_dec & mask_dec;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      samp_cnt   <= '0;
      bit_idx    <= '0;
      SAMPLE     <= 1'b0;
      RESULTP    <= '0;
      RESULTN    <= '0;
      VALID      <= 1'b0;
      BUSY       <= 1'b0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      OVERRUN    <= 1'b0;
`ifdef SARADC_CTRL_CMP_SYNC_EN
      phase      <= 2'd0;
`endif
    end else begin
      VALID <= 1'b0;
      if (DOUT_VALID && DOUT_READY) begin
        DOUT_VALID <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (START) begin
            state    <= S_SAMPLE;
            SAMPLE   <= 1'b1;
            BUSY     <= 1'b1;
            samp_cnt <= '0;
          end
        end

        S_SAMPLE: begin
          if (samp_cnt == CW'(NSAMP - 1)) begin
            state   <= S_CONVERT;
            SAMPLE  <= 1'b0;
            bit_idx <= KW'(NBITS - 1);
            RESULTP <= MSB_TRIAL;
            RESULTN <= '0;
`ifdef SARADC_CTRL_CMP_SYNC_EN
            phase   <= 2'd0;
`endif
          end else begin
            samp_cnt <= samp_cnt + CW'(1);
          end
        end

        S_CONVERT: begin
`ifdef SARADC_CTRL_CMP_SYNC_EN
          phase <= decide_now ? 2'd0 : phase + 2'd1;
`endif
          if (decide_now) begin
            RESULTP <= code_dec;
            RESULTN <= resn_dec;
            if (bit_idx == '0) begin
              state      <= S_DONE;
              VALID      <= 1'b1;
              DOUT       <= code_dec;
              DOUT_VALID <= 1'b1;
              // A same-cycle consume frees the slot, so only an unread result counts as overrun.
              OVERRUN    <= OVERRUN | (DOUT_VALID & ~DOUT_READY);
            end else begin
              bit_idx <= bit_idx - KW'(1);
            end
          end
        end

        S_DONE: begin
          RESULTP <= '0;
          RESULTN <= '0;
          if (CONT) begin
            state    <= S_SAMPLE;
            SAMPLE   <= 1'b1;
            samp_cnt <= '0;
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          SAMPLE <= 1'b0;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule
